regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Issue-stage scoreboard that sequences access to the 32×64 register file of the 5-stage pipeline. It tracks outstanding writes per architectural register, stalls issue on read-after-write and write-count overflow hazards, and retires entries when writeback commits through the single write port. It sits between decode/issue and the register file, next to the writeback `RegWrite`/`WriteRegister` path.

## Interface
Parameters:
- `CNT_W`, default 2: per-register pending-write counter width; max outstanding = 2^CNT_W−1.
- `PERF_W`, default 16: stall performance counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `IssueValid` in 1: an instruction is presented for issue.
- `IssueRs1`, `IssueRs2` in 5 each: source register numbers.
- `UseRs1`, `UseRs2` in 1 each: the source is actually read.
- `IssueRd` in 5: destination register.
- `IssueRdEn` in 1: the instruction writes `IssueRd`.
- `WbValid` in 1: writeback commits this cycle; same cycle as `RegWrite`.
- `WbRd` in 5: register being written back.
- `IssueStall` out 1: combinational; issue fires when `IssueValid & ~IssueStall`.
- `PendingAny` out 1: registered; any counter nonzero.
- `ScoreErr` out 1: registered, sticky; writeback to a register with count 0.
- `StallCycles` out `PERF_W`: registered, saturating count of cycles with `IssueValid & IssueStall`.

## Operation
- Register 31 (XZR) is never tracked. Its counter is constant 0, it never causes a stall, and issue/writeback to it are ignored.
- Stall conditions (OR):
  - `UseRs1` and count[`IssueRs1`] ≠ 0.
  - `UseRs2` and count[`IssueRs2`] ≠ 0.
  - `IssueRdEn` and count[`IssueRd`] = max (overflow guard).
- `IssueStall` is 0 when `IssueValid` = 0.
- Fire with `IssueRdEn`: count[`IssueRd`] += 1 at the next edge.
- `WbValid`: count[`WbRd`] −= 1 at the next edge.
- Same register incremented and decremented in the same cycle: count unchanged.
- `WbValid` to a register with count 0: count stays 0 (no underflow) and `ScoreErr` sets; only reset clears it.
- `StallCycles` saturates at all-ones and does not wrap.
- A fire whose Rd equals its own Rs does not self-stall in that cycle. Hazards are evaluated on pre-update counts.

## Timing
- Reset: all counters 0; `PendingAny` = 0, `ScoreErr` = 0, `StallCycles` = 0. `IssueStall` = 0 during reset regardless of inputs, and no updates occur.
- Stall decision has zero latency: it is combinational from the issue inputs and registered counts.
- Counter updates are visible one cycle after the fire or writeback edge.
- `PendingAny` reflects the counts after the update, i.e. it lags the triggering event by one cycle.
- Reset asserted mid-operation discards all pending state. Writebacks that arrive after reset release are then `ScoreErr` events.

## Configuration
- Macro `REGFILE_SB_BYPASS_EN`.
- Defined: a source hazard is suppressed when `WbValid & WbRd == src & count[src] == 1`. The register file is write-before-read, so the value is valid the same cycle.
- Undefined: that case stalls for exactly one extra cycle.
- Overflow stall logic is identical in both builds.

## Structure
- Shared package/header:
  - `REG_ZERO` = 31.
  - `NUM_REGS` = 32.
  - `REG_IDX_W` = 5.
  - Counter max derived from `CNT_W`.
- Sub-module `sb_counter`: one per-register saturating up/down counter with inc, dec, and underflow-flag outputs. It is instantiated 31 times.
- The top level holds:
  - decode of the issue Rd and `WbRd` into 32 one-hot enables;
  - two 32:1 count-zero selects;
  - the stall OR;
  - the perf counter.

## Test plan
- Reset, then issue rd=5 (fire) and next cycle issue rs1=5:
  - `IssueStall` = 1.
  - Assert `WbValid`/`WbRd`=5: stall clears in that cycle with BYPASS, one cycle later without.
- Issue rd=31 followed by rs1=31 → no stall ever; `PendingAny` stays 0.
- Three fires with rd=7, no writeback:
  - Fourth issue with rd=7 stalls.
  - One WB to 7 → fourth issue fires next cycle.
- Same-cycle fire rd=3 and WB rd=3 with count 1 → count stays 1; a source read of 3 still stalls.
- WB to rd=9 with count 0 → `ScoreErr` = 1 next cycle and stays 1 until `rst_n` = 0.
- Hold a stalling issue for 70000 cycles → `StallCycles` = 65535. Assert `rst_n` = 0 mid-run → all outputs return to 0 after one edge.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the register-file issue scoreboard.
// Imported by regfile_scoreboard and sb_counter.
package regfile_sb_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd31;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Largest value a CNT_W-bit pending-write counter may hold.
  function automatic int unsigned cnt_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_counter.sv
// Per-register pending-write counter: saturating up/down with an underflow flag.
// Simultaneous inc and dec leave the count unchanged.
module sb_counter
  import regfile_sb_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    count_d   = count_q;
    underflow = dec & (count_q == '0);
    if (inc && !dec && count_q != CNT_MAX) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-stage scoreboard for the 32x64 register file: RAW and overflow stalls,
// writeback retirement, sticky underflow error and saturating stall counter.
// Build option: define REGFILE_SB_BYPASS_EN to let a same-cycle final writeback clear a source hazard.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IssueValid,
  input  logic [4:0]        IssueRs1,
  input  logic [4:0]        IssueRs2,
  input  logic              UseRs1,
  input  logic              UseRs2,
  input  logic [4:0]        IssueRd,
  input  logic              IssueRdEn,
  input  logic              WbValid,
  input  logic [4:0]        WbRd,
  output logic              IssueStall,
  output logic              PendingAny,
  output logic              ScoreErr,
  output logic [PERF_W-1:0] StallCycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [NUM_REGS-1:0]            inc_en, dec_en, uflow;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0]               rs1_cnt, rs2_cnt, rd_cnt;
  logic                           rs1_haz, rs2_haz, ovf_haz, fire;

  logic              pending_any_q, pending_any_d;
  logic              score_err_q, score_err_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

  // XZR has no counter; its slot reads as permanently empty.
  for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_en[i]),
      .dec       (dec_en[i]),
      .count     (cnt[i]),
      .count_nxt (cnt_nxt[i]),
      .underflow (uflow[i])
    );
  end
  assign cnt[REG_ZERO]     = '0;
  assign cnt_nxt[REG_ZERO] = '0;
  assign uflow[REG_ZERO]   = 1'b0;

  assign rs1_cnt = cnt[IssueRs1];
  assign rs2_cnt = cnt[IssueRs2];
  assign rd_cnt  = cnt[IssueRd];

  // Hazards use pre-update counts, so an instruction never stalls on its own Rd.
  always_comb begin
    rs1_haz = UseRs1 & (rs1_cnt != '0);
    rs2_haz = UseRs2 & (rs2_cnt != '0);
`ifdef REGFILE_SB_BYPASS_EN
    if (WbValid && WbRd == IssueRs1 && rs1_cnt == CNT_W'(1)) rs1_haz = 1'b0;
    if (WbValid && WbRd == IssueRs2 && rs2_cnt == CNT_W'(1)) rs2_haz = 1'b0;
`endif
    ovf_haz    = IssueRdEn & (rd_cnt == CNT_MAX);
    IssueStall = rst_n & IssueValid & (rs1_haz | rs2_haz | ovf_haz);
    fire       = IssueValid & ~IssueStall;
  end

  always_comb begin
    inc_en = '0;
    dec_en = '0;
    if (fire && IssueRdEn && IssueRd != REG_ZERO) inc_en[IssueRd] = 1'b1;
    if (WbValid && WbRd != REG_ZERO)              dec_en[WbRd]    = 1'b1;
  end

  always_comb begin
    pending_any_d  = |cnt_nxt;
    score_err_d    = score_err_q | (|uflow);
    stall_cycles_d = stall_cycles_q;
    if (IssueValid && IssueStall && stall_cycles_q != '1) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_any_q  <= 1'b0;
      score_err_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      pending_any_q  <= pending_any_d;
      score_err_q    <= score_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign PendingAny  = pending_any_q;
  assign ScoreErr    = score_err_q;
  assign StallCycles = stall_cycles_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, corner
// sequences, and randomized traffic against an integer-count reference model.
module tb_regfile_scoreboard;

  localparam int CNT_W  = 2;
  localparam int PERF_W = 16;
  localparam int MAXC   = 3;
  localparam int PERF_MAX = 65535;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              IssueValid, UseRs1, UseRs2, IssueRdEn, WbValid;
  logic [4:0]        IssueRs1, IssueRs2, IssueRd, WbRd;
  logic              IssueStall, PendingAny, ScoreErr;
  logic [PERF_W-1:0] StallCycles;

  always #5 clk = ~clk;

  regfile_scoreboard #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IssueValid (IssueValid),
    .IssueRs1   (IssueRs1),
    .IssueRs2   (IssueRs2),
    .UseRs1     (UseRs1),
    .UseRs2     (UseRs2),
    .IssueRd    (IssueRd),
    .IssueRdEn  (IssueRdEn),
    .WbValid    (WbValid),
    .WbRd       (WbRd),
    .IssueStall (IssueStall),
    .PendingAny (PendingAny),
    .ScoreErr   (ScoreErr),
    .StallCycles(StallCycles)
  );

  typedef struct {
    bit       v;
    bit [4:0] rs1;
    bit       u1;
    bit [4:0] rs2;
    bit       u2;
    bit [4:0] rd;
    bit       rden;
    bit       wb;
    bit [4:0] wbrd;
    bit       e_stall;
    bit       e_pend;
    bit       e_err;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer outstanding-write counts per register.
  int m_cnt [32];
  bit m_err;
  int m_perf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit v, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                              bit [4:0] rd, bit rden, bit wb, bit [4:0] wbrd,
                              bit e_stall, bit e_pend, bit e_err);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.rd = rd; r.rden = rden; r.wb = wb; r.wbrd = wbrd;
    r.e_stall = e_stall; r.e_pend = e_pend; r.e_err = e_err;
    return r;
  endfunction

  task automatic drive(input vec_t t);
    IssueValid = t.v;
    IssueRs1   = t.rs1;
    UseRs1     = t.u1;
    IssueRs2   = t.rs2;
    UseRs2     = t.u2;
    IssueRd    = t.rd;
    IssueRdEn  = t.rden;
    WbValid    = t.wb;
    WbRd       = t.wbrd;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_err  = 0;
    m_perf = 0;
  endtask

  function automatic bit src_blocks(bit use_src, int src);
    bit bypass;
    if (!use_src || src == 31 || m_cnt[src] == 0) return 0;
    bypass = WbValid && int'(WbRd) == src && m_cnt[src] == 1;
`ifdef REGFILE_SB_BYPASS_EN
    return !bypass;
`else
    return 1;
`endif
  endfunction

  function automatic bit model_stall();
    if (!IssueValid) return 0;
    if (src_blocks(UseRs1, int'(IssueRs1))) return 1;
    if (src_blocks(UseRs2, int'(IssueRs2))) return 1;
    if (IssueRdEn && IssueRd != 5'd31 && m_cnt[IssueRd] == MAXC) return 1;
    return 0;
  endfunction

  task automatic model_update(input bit stall);
    int inc_r, dec_r;
    inc_r = (IssueValid && !stall && IssueRdEn && IssueRd != 5'd31) ? int'(IssueRd) : -1;
    dec_r = (WbValid && WbRd != 5'd31) ? int'(WbRd) : -1;
    if (dec_r >= 0 && m_cnt[dec_r] == 0) m_err = 1;
    if (!(inc_r >= 0 && inc_r == dec_r)) begin
      if (inc_r >= 0) m_cnt[inc_r]++;
      if (dec_r >= 0 && m_cnt[dec_r] > 0) m_cnt[dec_r]--;
    end
    if (IssueValid && stall && m_perf < PERF_MAX) m_perf++;
  endtask

  function automatic bit model_pending();
    for (int i = 0; i < 32; i++) if (m_cnt[i] > 0) return 1;
    return 0;
  endfunction

  function automatic bit [4:0] rand_reg();
    if ($urandom_range(0, 9) == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic rand_cycle();
    vec_t t;
    int   pend_list[$];
    bit   exp_stall;
    t = mk($urandom_range(0, 9) < 7, rand_reg(), $urandom_range(0, 1) == 1,
           rand_reg(), $urandom_range(0, 1) == 1, rand_reg(),
           $urandom_range(0, 3) != 0, 1'b0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 31; i++) if (m_cnt[i] > 0) pend_list.push_back(i);
    if (pend_list.size() > 0 && $urandom_range(0, 2) != 0) begin
      t.wb   = 1'b1;
      t.wbrd = 5'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
    end else if ($urandom_range(0, 7) == 0) begin
      t.wb   = 1'b1;
      t.wbrd = 5'd31;
    end
    drive(t);
    #4;
    exp_stall = model_stall();
    check("rand_stall", IssueStall, exp_stall);
    @(posedge clk);
    model_update(exp_stall);
    #1;
    check("rand_pending", PendingAny, model_pending());
    check("rand_err", ScoreErr, m_err);
    check("rand_perf", StallCycles, m_perf);
  endtask

  vec_t vecs[$];
  vec_t idle;
  int   tbl_perf;
  bit   bp;

  initial begin
`ifdef REGFILE_SB_BYPASS_EN
    bp = 1;
`else
    bp = 0;
`endif
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //            v  rs1 u1 rs2 u2 rd rden wb wbrd  stall pend err
    vecs.push_back(mk(1, 0,  0, 0,  0, 5,  1,  0, 0,   0,    1,   0)); // fire rd=5
    vecs.push_back(mk(1, 5,  1, 0,  0, 0,  0,  0, 0,   1,    1,   0)); // RAW on 5
    vecs.push_back(mk(1, 5,  1, 0,  0, 0,  0,  1, 5,   !bp,  0,   0)); // WB 5 same cycle
    vecs.push_back(mk(1, 5,  1, 0,  0, 0,  0,  0, 0,   0,    0,   0));
    vecs.push_back(mk(1, 0,  0, 0,  0, 31, 1,  0, 0,   0,    0,   0)); // XZR dest
    vecs.push_back(mk(1, 31, 1, 31, 1, 0,  0,  0, 0,   0,    0,   0)); // XZR sources
    vecs.push_back(mk(1, 0,  0, 0,  0, 7,  1,  0, 0,   0,    1,   0));
    vecs.push_back(mk(1, 0,  0, 0,  0, 7,  1,  0, 0,   0,    1,   0));
    vecs.push_back(mk(1, 0,  0, 0,  0, 7,  1,  0, 0,   0,    1,   0));
    vecs.push_back(mk(1, 0,  0, 0,  0, 7,  1,  0, 0,   1,    1,   0)); // overflow guard
    vecs.push_back(mk(1, 0,  0, 0,  0, 7,  1,  1, 7,   1,    1,   0)); // WB frees a slot
    vecs.push_back(mk(1, 0,  0, 0,  0, 7,  1,  0, 0,   0,    1,   0)); // fourth fires
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0,  1, 7,   0,    1,   0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0,  1, 7,   0,    1,   0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0,  1, 7,   0,    0,   0));
    vecs.push_back(mk(1, 0,  0, 0,  0, 3,  1,  0, 0,   0,    1,   0));
    vecs.push_back(mk(1, 0,  0, 0,  0, 3,  1,  1, 3,   0,    1,   0)); // inc+dec on 3
    vecs.push_back(mk(1, 3,  1, 0,  0, 0,  0,  0, 0,   1,    1,   0)); // 3 still pending
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0,  1, 3,   0,    0,   0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0,  1, 9,   0,    0,   1)); // underflow
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0,  0, 0,   0,    0,   1)); // sticky

    rst_n = 1'b0;
    drive(mk(1, 1, 1, 2, 1, 3, 1, 1, 4, 0, 0, 0));
    #2;
    check("reset_stall_comb", IssueStall, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_pending", PendingAny, 0);
    check("reset_err", ScoreErr, 0);
    check("reset_perf", StallCycles, 0);
    drive(idle);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl_perf = 0;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      #4;
      check($sformatf("tbl%0d_stall", i), IssueStall, vecs[i].e_stall);
      if (vecs[i].v && vecs[i].e_stall) tbl_perf++;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_pending", i), PendingAny, vecs[i].e_pend);
      check($sformatf("tbl%0d_err", i), ScoreErr, vecs[i].e_err);
    end
    check("tbl_perf", StallCycles, tbl_perf);

    rst_n = 1'b0;
    drive(idle);
    @(posedge clk);
    #1;
    check("clr_err", ScoreErr, 0);
    check("clr_perf", StallCycles, 0);
    rst_n = 1'b1;
    model_reset();

    for (int n = 0; n < 3000; n++) rand_cycle();

    // Mid-run reset with live traffic: no stall while in reset, all state discarded.
    rst_n = 1'b0;
    drive(mk(1, 0, 1, 1, 1, 2, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) if (m_cnt[i] > 0) IssueRs1 = 5'(i);
    #4;
    check("midrst_stall_comb", IssueStall, 0);
    @(posedge clk);
    #1;
    check("midrst_pending", PendingAny, 0);
    check("midrst_err", ScoreErr, 0);
    check("midrst_perf", StallCycles, 0);
    drive(idle);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0));
    @(posedge clk);
    #1;
    check("post_rst_wb_err", ScoreErr, 1);
    check("post_rst_wb_pending", PendingAny, 0);

    // Saturating stall counter.
    rst_n = 1'b0;
    drive(idle);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    drive(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check("sat_stall", IssueStall, 1);
    repeat (PERF_MAX - 1) @(posedge clk);
    #1;
    check("sat_perf_below", StallCycles, PERF_MAX - 1);
    @(posedge clk);
    #1;
    check("sat_perf_max", StallCycles, PERF_MAX);
    repeat (70000 - PERF_MAX) @(posedge clk);
    #1;
    check("sat_perf_hold", StallCycles, PERF_MAX);
    check("sat_pending", PendingAny, 1);

    rst_n = 1'b0;
    #2;
    check("sat_rst_stall_comb", IssueStall, 0);
    @(posedge clk);
    #1;
    check("sat_rst_perf", StallCycles, 0);
    check("sat_rst_pending", PendingAny, 0);
    check("sat_rst_err", ScoreErr, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("sat_rst_discard", IssueStall, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
